// File: rtl/pdm_ddr_deser_stream.sv
// DDR capture of PDM microphone lines: deinterleaves rising/falling-edge bits into per-channel
// MSB-first words, holds one completed frame and streams it out one channel per handshake.
module pdm_ddr_deser_stream #(
    parameter int NUM_LINES = 2,
    parameter int WORD_W    = 16,
    localparam int CH_W     = (2 * NUM_LINES > 1) ? $clog2(2 * NUM_LINES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LINES-1:0] ddr_data,
    input  logic                 en,
    input  logic                 swap_edges,
    output logic [WORD_W-1:0]    out_data,
    output logic [CH_W-1:0]      out_chan,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int NCH   = 2 * NUM_LINES;
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_W - 1);
    localparam logic [CH_W-1:0]  CHAN_MAX = CH_W'(NCH - 1);

    logic [NUM_LINES-1:0]         rise_q;
    logic [NUM_LINES-1:0]         fall_q;
    logic [NCH-1:0][WORD_W-1:0]   shift_q;
    logic [NCH-1:0][WORD_W-1:0]   shift_d;
    logic [NCH-1:0][WORD_W-1:0]   hold_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [CH_W-1:0]              chan_q;
    logic                         hold_full_q;
    logic                         ovf_q;

    logic frame_done;
    logic handshake;
    logic last_hs;
    logic hold_free;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rise_q <= '0;
        else      rise_q <= ddr_data;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) fall_q <= '0;
        else      fall_q <= ddr_data;
    end

    // Each posedge shifts in the pair captured over the previous full clock period.
    always_comb begin
        shift_d = shift_q;
        for (int l = 0; l < NUM_LINES; l++) begin
            shift_d[2*l]   = {shift_q[2*l][WORD_W-2:0],   swap_edges ? fall_q[l] : rise_q[l]};
            shift_d[2*l+1] = {shift_q[2*l+1][WORD_W-2:0], swap_edges ? rise_q[l] : fall_q[l]};
        end
    end

    assign frame_done = en && (cnt_q == CNT_MAX);
    assign handshake  = hold_full_q && out_ready;
    assign last_hs    = handshake && (chan_q == CHAN_MAX);
    // Draining the last channel on the completing edge frees the buffer for the new frame.
    assign hold_free  = !hold_full_q || last_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            shift_q <= shift_d;
            cnt_q   <= frame_done ? '0 : cnt_q + 1'b1;
        end else begin
            shift_q <= '0;
            cnt_q   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (frame_done && hold_free) begin
            hold_q      <= shift_d;
            hold_full_q <= 1'b1;
        end else if (last_hs) begin
            hold_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_q <= '0;
        end else if (handshake) begin
            chan_q <= last_hs ? '0 : chan_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (frame_done && !hold_free) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign out_data  = hold_q[chan_q];
    assign out_chan  = chan_q;
    assign out_valid = hold_full_q;
    assign out_last  = hold_full_q && (chan_q == CHAN_MAX);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pdm_ddr_deser_stream.sv
// Directed bench for pdm_ddr_deser_stream: table of frames with hand-computed channel words,
// plus sequences for stall, overflow, exact-edge refill, enable drop and mid-drain reset.
module tb_pdm_ddr_deser_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  ddr_data = '0;
    logic        en = 1'b0;
    logic        swap_edges = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    pdm_ddr_deser_stream #(
        .NUM_LINES(2),
        .WORD_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ddr_data  (ddr_data),
        .en        (en),
        .swap_edges(swap_edges),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]         r0, f0, r1, f1;
        logic                swap;
        logic [0:3][15:0]    e;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Pair i carries bit 15-i; en rises just after the posedge that captured the first R.
    task automatic send_bits(input logic [15:0] r0, input logic [15:0] f0, input logic [15:0] r1,
                             input logic [15:0] f1, input int n, input logic [15:0] rdy_mask);
        for (int i = 0; i < n; i++) begin
            ddr_data = {r1[15-i], r0[15-i]};
            @(posedge clk);
            #1;
            en        = 1'b1;
            out_ready = rdy_mask[i];
            ddr_data  = {f1[15-i], f0[15-i]};
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_vec(input int idx, input logic [15:0] rdy_mask);
        swap_edges = vecs[idx].swap;
        send_bits(vecs[idx].r0, vecs[idx].f0, vecs[idx].r1, vecs[idx].f1, 16, rdy_mask);
    endtask

    task automatic finish_frame(input logic rdy, input logic clr);
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
        en      = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic drain_check(input string name, input logic [0:3][15:0] e);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check({name, " valid"}, 32'(out_valid), 32'd1);
            check({name, " chan"},  32'(out_chan),  32'(c));
            check({name, " data"},  32'(out_data),  32'(e[c]));
            check({name, " last"},  32'(out_last),  32'(c == 3));
            @(posedge clk);
            #1;
        end
        check({name, " empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{r0: 16'hFFFF, f0: 16'h0000, r1: 16'h0000, f1: 16'hFFFF, swap: 1'b0,
                    e: {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}};
        vecs[1] = '{r0: 16'hFFFF, f0: 16'h0000, r1: 16'h0000, f1: 16'hFFFF, swap: 1'b1,
                    e: {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000}};
        vecs[2] = '{r0: 16'hAAAA, f0: 16'h1234, r1: 16'h00FF, f1: 16'h8001, swap: 1'b0,
                    e: {16'hAAAA, 16'h1234, 16'h00FF, 16'h8001}};
        vecs[3] = '{r0: 16'hAAAA, f0: 16'h1234, r1: 16'h00FF, f1: 16'h8001, swap: 1'b1,
                    e: {16'h1234, 16'hAAAA, 16'h8001, 16'h00FF}};

        #12;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst chan",  32'(out_chan),  32'd0);
        check("rst data",  32'(out_data),  32'd0);
        check("rst last",  32'(out_last),  32'd0);
        check("rst ovf",   32'(overflow),  32'd0);
        rst = 1'b1;

        // Table: each frame captured, then drained with ready held high.
        for (int v = 0; v < 4; v++) begin
            send_vec(v, 16'hFFFF);
            finish_frame(1'b1, 1'b0);
            drain_check($sformatf("vec%0d", v), vecs[v].e);
        end

        // Stall on channel 1 for five cycles.
        send_vec(2, 16'hFFFF);
        finish_frame(1'b1, 1'b0);
        check("stall ch0", 32'(out_data), 32'hAAAA);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall chan", 32'(out_chan), 32'd1);
            check("stall data", 32'(out_data), 32'h1234);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int c = 1; c < 4; c++) begin
            check("stall resume", 32'(out_data), 32'(vecs[2].e[c]));
            @(posedge clk);
            #1;
        end
        check("stall empty", 32'(out_valid), 32'd0);

        // Two frames with no ready: first retained, second dropped.
        send_vec(2, 16'h0000);
        send_vec(0, 16'h0000);
        finish_frame(1'b0, 1'b0);
        check("ovf set", 32'(overflow), 32'd1);
        drain_check("ovf keep", vecs[2].e);
        check("ovf sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check("ovf clr", 32'(overflow), 32'd0);

        // Clear coinciding with a drop: drop wins.
        send_vec(3, 16'h0000);
        finish_frame(1'b0, 1'b0);
        check("ovf pre", 32'(overflow), 32'd0);
        send_vec(0, 16'h0000);
        finish_frame(1'b0, 1'b1);
        check("ovf clr+drop", 32'(overflow), 32'd1);
        drain_check("ovf keep2", vecs[3].e);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;

        // Last channel drained on the exact frame-complete edge: refill, no overflow.
        send_vec(2, 16'h0000);
        finish_frame(1'b0, 1'b0);
        send_vec(3, 16'h7000);
        check("edge chan3", 32'(out_chan), 32'd3);
        finish_frame(1'b1, 1'b0);
        check("edge ovf", 32'(overflow), 32'd0);
        drain_check("edge refill", vecs[3].e);

        // Enable drop after 7 bits discards the partial frame.
        swap_edges = 1'b0;
        send_bits(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 7, 16'hFFFF);
        finish_frame(1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("en partial", 32'(out_valid), 32'd0);
        send_vec(2, 16'hFFFF);
        finish_frame(1'b1, 1'b0);
        drain_check("en fresh", vecs[2].e);

        // Reset in the middle of draining.
        send_vec(0, 16'h0000);
        finish_frame(1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pre-rst chan", 32'(out_chan), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst valid2", 32'(out_valid), 32'd0);
        check("rst chan2",  32'(out_chan),  32'd0);
        check("rst data2",  32'(out_data),  32'd0);
        check("rst last2",  32'(out_last),  32'd0);
        #1;
        rst = 1'b1;
        send_vec(1, 16'hFFFF);
        finish_frame(1'b1, 1'b0);
        drain_check("post-rst", vecs[1].e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
